// File: rtl/decode_queue_pkg.sv
// rtl/decode_queue_pkg.sv - shared types for the RV32 decode queue: op classes, opcodes, micro-op struct
package decode_pkg;

  typedef enum logic [3:0] {
    CL_LUI      = 4'd0,
    CL_AUIPC    = 4'd1,
    CL_JAL      = 4'd2,
    CL_JALR     = 4'd3,
    CL_BRANCH   = 4'd4,
    CL_LOAD     = 4'd5,
    CL_STORE    = 4'd6,
    CL_OP_IMM   = 4'd7,
    CL_OP       = 4'd8,
    CL_MISC_MEM = 4'd9,
    CL_SYSTEM   = 4'd10,
    CL_MULDIV   = 4'd11,
    CL_ILLEGAL  = 4'd12
  } dq_class_e;

  // Major opcodes are instr[6:2]; instr[1:0] must be 2'b11 separately.
  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  typedef struct packed {
    dq_class_e   cls;
    logic [2:0]  funct3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        wr_valid;
    logic        illegal;
    logic [31:0] pc;
  } dq_uop_t;

endpackage

// File: rtl/decode_queue_if.sv
// rtl/decode_queue_if.sv - fetch-side and issue-side handshakes of the decode queue
interface decode_queue_if;
  import decode_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;

  logic        out_valid;
  logic        out_ready;
  dq_class_e   out_class;
  logic [2:0]  out_funct3;
  logic        out_alt;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [31:0] out_imm;
  logic        out_wr_valid;
  logic        out_illegal;
  logic [31:0] out_pc;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_class, out_funct3, out_alt, out_rd, out_rs1,
           out_rs2, out_imm, out_wr_valid, out_illegal, out_pc
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_class, out_funct3, out_alt, out_rd, out_rs1,
           out_rs2, out_imm, out_wr_valid, out_illegal, out_pc
  );

endinterface

// File: rtl/decode_queue_decode.sv
// rtl/decode_queue_decode.sv - combinational RV32I decoder (RV32M when DECODE_RV32M_EN is defined)
module rv32_decode_comb
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output dq_uop_t     uop
);

  logic [4:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  dq_class_e   cls;
  logic        legal;
  logic        writes;
  logic        alt;
  logic [31:0] imm;

  assign opc    = instr[6:2];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_sh = {27'b0, instr[24:20]};

  always_comb begin
    cls    = CL_ILLEGAL;
    legal  = 1'b0;
    writes = 1'b0;
    alt    = 1'b0;
    imm    = '0;
    if (instr[1:0] == 2'b11) begin
      case (opc)
        OPC_LUI:   begin cls = CL_LUI;   legal = 1'b1; writes = 1'b1; imm = imm_u; end
        OPC_AUIPC: begin cls = CL_AUIPC; legal = 1'b1; writes = 1'b1; imm = imm_u; end
        OPC_JAL:   begin cls = CL_JAL;   legal = 1'b1; writes = 1'b1; imm = imm_j; end
        OPC_JALR:  begin cls = CL_JALR;  legal = (f3 == 3'b000); writes = 1'b1; imm = imm_i; end
        OPC_BRANCH: begin
          cls   = CL_BRANCH;
          legal = (f3 != 3'b010) && (f3 != 3'b011);
          imm   = imm_b;
        end
        OPC_LOAD: begin
          cls    = CL_LOAD;
          legal  = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
          writes = 1'b1;
          imm    = imm_i;
        end
        OPC_STORE: begin cls = CL_STORE; legal = (f3 < 3'b011); imm = imm_s; end
        OPC_OP_IMM: begin
          cls    = CL_OP_IMM;
          writes = 1'b1;
          if (f3 == 3'b001) begin
            legal = (f7 == 7'h00);
            imm   = imm_sh;
            alt   = instr[30];
          end else if (f3 == 3'b101) begin
            legal = (f7 == 7'h00) || (f7 == 7'h20);
            imm   = imm_sh;
            alt   = instr[30];
          end else begin
            legal = 1'b1;
            imm   = imm_i;
          end
        end
        OPC_OP: begin
          writes = 1'b1;
          alt    = instr[30];
          if (f7 == 7'h00) begin
            cls   = CL_OP;
            legal = 1'b1;
          end else if (f7 == 7'h20) begin
            cls   = CL_OP;
            legal = (f3 == 3'b000) || (f3 == 3'b101);
`ifdef DECODE_RV32M_EN
          end else if (f7 == 7'h01) begin
            cls   = CL_MULDIV;
            legal = 1'b1;
`endif
          end
        end
        OPC_MISC_MEM: begin cls = CL_MISC_MEM; legal = (f3 == 3'b000) || (f3 == 3'b001); end
        OPC_SYSTEM: begin
          cls = CL_SYSTEM;
          imm = imm_i;
          // funct3=000 only admits ECALL/EBREAK; the CSR forms write rd.
          if (f3 == 3'b000) begin
            legal = (instr[31:21] == 11'd0) && (rd == 5'd0) && (rs1 == 5'd0);
          end else begin
            legal  = (f3 != 3'b100);
            writes = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    uop          = '0;
    uop.cls      = legal ? cls : CL_ILLEGAL;
    uop.funct3   = f3;
    uop.alt      = legal & alt;
    uop.rd       = rd;
    uop.rs1      = rs1;
    uop.rs2      = instr[24:20];
    uop.imm      = legal ? imm : 32'd0;
    uop.wr_valid = legal & writes & (rd != 5'd0);
    uop.illegal  = ~legal;
  end

endmodule

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - decode stage with a DEPTH-entry micro-op FIFO, flush and illegal counter (option: DECODE_RV32M_EN)
module decode_queue
  import decode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  decode_queue_if.slave    io,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  dq_uop_t       dec_uop;
  dq_uop_t       wr_uop;
  dq_uop_t       head_uop;
  dq_uop_t       mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  logic          push;
  logic          pop;

  rv32_decode_comb u_decode (
    .instr (io.in_instr),
    .uop   (dec_uop)
  );

  always_comb begin
    wr_uop    = dec_uop;
    wr_uop.pc = io.in_pc;
  end

  // Readiness looks only at the registered count, so a pop never frees a slot for the same cycle.
  assign io.in_ready  = (count < FULL);
  assign io.out_valid = (count != '0);
  assign push = io.in_valid & io.in_ready & ~flush;
  assign pop  = io.out_valid & io.out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      illegal_cnt <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (push && dec_uop.illegal && (illegal_cnt != '1)) illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= wr_uop;
  end

  assign head_uop        = mem[head];
  assign io.out_class    = head_uop.cls;
  assign io.out_funct3   = head_uop.funct3;
  assign io.out_alt      = head_uop.alt;
  assign io.out_rd       = head_uop.rd;
  assign io.out_rs1      = head_uop.rs1;
  assign io.out_rs2      = head_uop.rs2;
  assign io.out_imm      = head_uop.imm;
  assign io.out_wr_valid = head_uop.wr_valid;
  assign io.out_illegal  = head_uop.illegal;
  assign io.out_pc       = head_uop.pc;

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - randomized bench for decode_queue against a queue-based reference model
module tb_decode_queue;
  import decode_pkg::*;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef DECODE_RV32M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [CNT_W-1:0] illegal_cnt;
  int               total = 0;
  int               bad = 0;
  dq_uop_t          mq[$];
  int               mcnt = 0;

  decode_queue_if io();

  decode_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .io          (io.slave),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic dq_uop_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    dq_uop_t    u;
    dq_class_e  c;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       nok;
    f3 = w[14:12];
    f7 = w[31:25];
    case (w[6:0])
      7'h37: c = CL_LUI;
      7'h17: c = CL_AUIPC;
      7'h6F: c = CL_JAL;
      7'h67: c = CL_JALR;
      7'h63: c = CL_BRANCH;
      7'h03: c = CL_LOAD;
      7'h23: c = CL_STORE;
      7'h13: c = CL_OP_IMM;
      7'h33: c = CL_OP;
      7'h0F: c = CL_MISC_MEM;
      7'h73: c = CL_SYSTEM;
      default: c = CL_ILLEGAL;
    endcase
    if (c == CL_OP && f7 == 7'h01) c = M_EN ? CL_MULDIV : CL_ILLEGAL;
    case (c)
      CL_ILLEGAL:  nok = 1'b1;
      CL_JALR:     nok = (f3 != 0);
      CL_BRANCH:   nok = (f3 == 2) || (f3 == 3);
      CL_LOAD:     nok = (f3 == 3) || (f3 >= 6);
      CL_STORE:    nok = (f3 >= 3);
      CL_OP:       nok = (f7 != 0) && !(f7 == 7'h20 && (f3 == 0 || f3 == 5));
      CL_OP_IMM:   nok = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20);
      CL_MISC_MEM: nok = (f3 > 1);
      CL_SYSTEM:   nok = (f3 == 4) || (f3 == 0 && !(w[31:21] == 0 && w[11:7] == 0 && w[19:15] == 0));
      default:     nok = 1'b0;
    endcase
    u        = '0;
    u.funct3 = f3;
    u.rd     = w[11:7];
    u.rs1    = w[19:15];
    u.rs2    = w[24:20];
    u.pc     = pc;
    u.illegal = nok;
    if (nok) begin
      u.cls = CL_ILLEGAL;
    end else begin
      u.cls = c;
      case (c)
        CL_LUI, CL_AUIPC: u.imm = {w[31:12], 12'h000};
        CL_JAL:    u.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
        CL_BRANCH: u.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
        CL_STORE:  u.imm = 32'($signed({w[31:25], w[11:7]}));
        CL_OP_IMM: u.imm = (f3 == 1 || f3 == 5) ? 32'(w[24:20]) : 32'($signed(w[31:20]));
        CL_LOAD, CL_JALR, CL_SYSTEM: u.imm = 32'($signed(w[31:20]));
        default:   u.imm = 32'd0;
      endcase
      u.alt = (c == CL_OP || c == CL_MULDIV || (c == CL_OP_IMM && (f3 == 1 || f3 == 5))) ? w[30] : 1'b0;
      u.wr_valid = (w[11:7] != 0) &&
                   (c inside {CL_LUI, CL_AUIPC, CL_JAL, CL_JALR, CL_LOAD, CL_OP_IMM, CL_OP, CL_MULDIV} ||
                    (c == CL_SYSTEM && f3 != 0));
    end
    return u;
  endfunction

  // Compare the DUT with the model at the negedge, then advance both across one posedge.
  task automatic cycle();
    dq_uop_t e;
    bit      do_push;
    bit      do_pop;
    chk("out_valid", io.out_valid, mq.size() != 0);
    chk("in_ready", io.in_ready, mq.size() < DEPTH);
    chk("illegal_cnt", illegal_cnt, mcnt);
    if (mq.size() != 0) begin
      e = mq[0];
      chk("class", io.out_class, e.cls);
      chk("regs", {io.out_funct3, io.out_rd, io.out_rs1, io.out_rs2}, {e.funct3, e.rd, e.rs1, e.rs2});
      chk("imm", io.out_imm, e.imm);
      chk("flags", {io.out_alt, io.out_wr_valid, io.out_illegal}, {e.alt, e.wr_valid, e.illegal});
      chk("pc", io.out_pc, e.pc);
    end
    do_push = io.in_valid && (mq.size() < DEPTH) && !flush;
    do_pop  = (mq.size() != 0) && io.out_ready && !flush;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mcnt = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e = ref_decode(io.in_instr, io.in_pc);
        mq.push_back(e);
        if (e.illegal && mcnt < CNT_MAX) mcnt++;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit rdy, input bit fl);
    io.in_valid  = v;
    io.in_instr  = ins;
    io.in_pc     = pc;
    io.out_ready = rdy;
    flush        = fl;
    cycle();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 3);
    if (k == 0) w[31:25] = 7'h00;
    else if (k == 1) w[31:25] = 7'h20;
    else if (k == 2) w[31:25] = 7'h01;
    case ($urandom_range(0, 12))
      0:  w[6:0] = 7'h37;
      1:  w[6:0] = 7'h17;
      2:  w[6:0] = 7'h6F;
      3:  w[6:0] = 7'h67;
      4:  w[6:0] = 7'h63;
      5:  w[6:0] = 7'h03;
      6:  w[6:0] = 7'h23;
      7:  w[6:0] = 7'h13;
      8:  w[6:0] = 7'h33;
      9:  w[6:0] = 7'h0F;
      10: w[6:0] = 7'h73;
      11: w = {11'b0, w[20], 5'b0, 3'b0, 5'b0, 7'h73};
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    io.in_valid = 1'b0;
    io.in_instr = '0;
    io.in_pc = '0;
    io.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_out_valid", io.out_valid, 1'b0);
    chk("rst_in_ready", io.in_ready, 1'b1);
    chk("rst_illegal_cnt", illegal_cnt, 0);
    drive(0, 0, 0, 0, 0);

    drive(1, 32'h0050_0093, 32'h100, 0, 0);
    chk("addi_valid", io.out_valid, 1'b1);
    chk("addi_class", io.out_class, CL_OP_IMM);
    chk("addi_regs", {io.out_rd, io.out_rs1}, {5'd1, 5'd0});
    chk("addi_imm", io.out_imm, 32'd5);
    chk("addi_flags", {io.out_wr_valid, io.out_illegal}, 2'b10);
    chk("addi_pc", io.out_pc, 32'h100);
    drive(0, 0, 0, 1, 0);

    drive(1, 32'h1234_5137, 32'h200, 1, 0);
    chk("lui_class", io.out_class, CL_LUI);
    chk("lui_imm", io.out_imm, 32'h1234_5000);
    drive(1, 32'hFE00_0EE3, 32'h204, 1, 0);
    chk("beq_class", io.out_class, CL_BRANCH);
    chk("beq_imm", io.out_imm, 32'hFFFF_FFFC);
    chk("beq_wr", io.out_wr_valid, 1'b0);
    drive(0, 0, 0, 1, 0);

    drive(1, 32'h0220_81B3, 32'h300, 0, 0);
    if (M_EN) begin
      chk("mul_class", io.out_class, CL_MULDIV);
      chk("mul_rd", {io.out_rd, io.out_illegal}, {5'd3, 1'b0});
    end else begin
      chk("mul_illegal", io.out_illegal, 1'b1);
      chk("mul_cnt", illegal_cnt, 1);
    end
    drive(0, 0, 0, 1, 0);

    for (int i = 0; i < DEPTH + 1; i++) drive(1, 32'h0000_0093 | (i << 20), 32'h400 + 4 * i, 0, 0);
    chk("full_in_ready", io.in_ready, 1'b0);
    chk("full_head_pc", io.out_pc, 32'h400);
    for (int i = 0; i < DEPTH + 1; i++) drive(0, 0, 0, 1, 0);
    chk("drained", io.out_valid, 1'b0);

    for (int i = 0; i < 3; i++) drive(1, 32'h0010_0113, 32'h500 + 4 * i, 0, 0);
    drive(1, 32'h0020_0113, 32'h50C, 0, 1);
    chk("flush_valid", io.out_valid, 1'b0);
    chk("flush_ready", io.in_ready, 1'b1);
    drive(0, 0, 0, 0, 0);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    rst = 1'b0;
    drive(1, 32'h0000_0000, 32'h600, 1, 0);
    drive(1, 32'h0000_707F, 32'h604, 1, 0);
    drive(1, 32'hFFFF_FFFF, 32'h608, 1, 0);
    chk("ill_cnt3", illegal_cnt, 3);
    for (int i = 0; i < 6; i++) drive(1, 32'hFFFF_FFFF, 32'h700 + 4 * i, 1, 0);
    chk("ill_sat", illegal_cnt, CNT_MAX);
    drive(0, 0, 0, 1, 0);

    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 9) < 7, rand_instr(), $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
    end
    rst = 1'b0;
    drive(0, 0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
